// File: rtl/stream_sink_fifo_pkg.sv
// Shared constants for the stream sink FIFO slice: bus width and upstream delay-line length.
// They set the default WIDTH and AF_MARGIN of stream_sink_fifo.
package stream_sink_fifo_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int DELAY_LEN = 2;

    // Occupancy at which the producer must be told to stop.
    function automatic int af_level(input int depth, input int margin);
        return depth - margin;
    endfunction

endpackage

// File: rtl/stream_sink_regfile.sv
// DEPTH x WIDTH storage for stream_sink_fifo.
// It has one synchronous write port and one asynchronous read port, and it is never reset.
module stream_sink_regfile
    import stream_sink_fifo_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_sink_fifo.sv
// Buffers the non-stallable {data, valid} stream from the delay stage behind a valid/ready port.
// Define STREAM_SINK_FIFO_BYPASS_EN to enable zero-latency cut-through while the FIFO is empty.
module stream_sink_fifo
    import stream_sink_fifo_pkg::*;
#(
    parameter int WIDTH     = BUS_WIDTH,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = DELAY_LEN + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   almost_full,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(af_level(DEPTH, AF_MARGIN));

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rd_data;
    logic             bypass, thru, pop, push, drop, we, rd_adv;

`ifdef STREAM_SINK_FIFO_BYPASS_EN
    assign bypass = (count_q == '0) && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (count_q != '0) || bypass;
    assign out_data  = bypass ? in_data : rd_data;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((count_q < FULL_LVL) || pop);
    assign drop      = in_valid && !push;
    // A cut-through word that is consumed right away never touches storage or count.
    assign thru      = bypass && out_ready;
    assign we        = push && !thru;
    assign rd_adv    = pop && !thru;

    always_comb begin
        wr_ptr_d = we ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(we) - CW'(rd_adv);
        // The flag follows the current count, so it lags occupancy by one cycle; AF_MARGIN covers that lag.
        af_d     = (count_q >= AF_LVL);
        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign count       = count_q;

    stream_sink_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stream_sink_fifo.sv
// Self-checking bench for stream_sink_fifo with DEPTH=8, AF_MARGIN=3 and WIDTH=32.
// A queue-based reference model predicts occupancy, head data and the flags.
module tb_stream_sink_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        almost_full;
    logic        overflow;
    logic        ovf_clr;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic        m_ovf;
    logic        m_af;
    logic        exp_pop_vld;
    logic [31:0] exp_pop_data;
    logic        obs_valid;
    logic [31:0] obs_data;

    always #5 clk = ~clk;

    stream_sink_fifo #(
        .WIDTH     (32),
        .DEPTH     (8),
        .AF_MARGIN (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .count       (count)
    );

    // One clock of stimulus. It captures the pre-edge outputs, then advances the model past the edge.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
        bit do_pop, do_push, thru, drop;
        in_valid = v; in_data = d; out_ready = r; ovf_clr = c;
        #1;
        obs_valid = out_valid;
        obs_data  = out_data;
        thru = 1'b0;
`ifdef STREAM_SINK_FIFO_BYPASS_EN
        thru = (mq.size() == 0) && v && r;
`endif
        do_pop  = (mq.size() != 0) && r;
        do_push = v && !thru && ((mq.size() < 8) || do_pop);
        drop    = v && !thru && !do_push;
        exp_pop_vld  = do_pop || thru;
        exp_pop_data = do_pop ? mq[0] : d;
        @(posedge clk);
        m_af = (mq.size() >= 5);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        #1;
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_af  = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 32'h100 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd5 || overflow !== 1'b1 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: count=%0d ovf=%b af=%b, required count=5 ovf=1 af=1", count, overflow, almost_full);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, required 0", count);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_checks++;
        if (almost_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_almost_full: got %b, required 0", almost_full);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow);
        end
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 32'h11 + i, 1'b0, 1'b0);
            n_checks++;
            if (count !== 4'(i + 1) || almost_full !== ((i + 1) >= 6)) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d af=%b, required count=%0d af=%b", i, count, almost_full, i + 1, (i + 1) >= 6);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h11) begin
                n_fail++;
                $display("FAIL fill_head_%0d: valid=%b data=%h, required valid=1 data=00000011", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 32'hAA, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf=%b count=%0d head=%h, required ovf=1 count=8 head=00000011", overflow, count, out_data);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr: got %b, required 0", overflow);
        end
        drive_cycle(1'b1, 32'hCC, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: got %b, required 1", overflow);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            n_fail++; $display("FAIL ovf_clr2: ovf=%b count=%0d, required ovf=0 count=8", overflow, count);
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] exp_seq [8];
        drive_cycle(1'b1, 32'hBB, 1'b1, 1'b0);
        n_checks++;
        if (obs_data !== 32'h11 || count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_swap: popped=%h count=%0d ovf=%b, required popped=00000011 count=8 ovf=0", obs_data, count, overflow);
        end
        for (int i = 0; i < 7; i++) exp_seq[i] = 32'h12 + i;
        exp_seq[7] = 32'hBB;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_data !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%b data=%h, required valid=1 data=%h", i, obs_valid, obs_data, exp_seq[i]);
            end
        end
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: count=%0d valid=%b, required count=0 valid=0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 20; i++) begin
            drive_cycle(i < 20, 32'(i), 1'b1, 1'b0);
            n_checks++;
            if (obs_valid !== (i > 0) || (i > 0 && obs_data !== 32'(i - 1))) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_valid, obs_data, i > 0, i - 1);
            end
            n_checks++;
            if (count > 4'd1) begin
                n_fail++; $display("FAIL b2b_count_%0d: got %0d, required <= 1", i, count);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            if (exp_pop_vld) begin
                n_checks++;
                if (obs_data !== exp_pop_data) begin
                    n_fail++; $display("FAIL rnd_pop_%0d: got %h, required %h", i, obs_data, exp_pop_data);
                end
            end
            n_checks++;
            if (count !== 4'(mq.size()) || out_valid !== (mq.size() != 0) ||
                almost_full !== m_af || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_state_%0d: count=%0d valid=%b af=%b ovf=%b, required count=%0d valid=%b af=%b ovf=%b",
                         i, count, out_valid, almost_full, overflow, mq.size(), mq.size() != 0, m_af, m_ovf);
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (out_data !== mq[0]) begin
                    n_fail++; $display("FAIL rnd_head_%0d: got %h, required %h", i, out_data, mq[0]);
                end
            end
        end
    endtask

`ifdef STREAM_SINK_FIFO_BYPASS_EN
    task automatic test_bypass();
        while (mq.size() != 0) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5A) begin
            n_fail++; $display("FAIL bypass_same_cycle: valid=%b data=%h, required valid=1 data=0000005a", out_valid, out_data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++; $display("FAIL bypass_count: got %0d, required 0", count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_overflow();
        test_full_pop_push();
        test_back_to_back();
        test_random();
`ifdef STREAM_SINK_FIFO_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
